// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU sequencer: opcodes, ALU selects,
// FSM state codes and the datapath control bundle.
package cpu_pkg;

   localparam int unsigned OP_W    = 3;
   localparam int unsigned ALU_W   = 2;
   localparam int unsigned STATE_W = 3;
   localparam int unsigned WAIT_W  = 8;

   // Instruction opcodes
   localparam logic [OP_W-1:0] OP_HLT = 3'b000;
   localparam logic [OP_W-1:0] OP_SKZ = 3'b001;
   localparam logic [OP_W-1:0] OP_ADD = 3'b010;
   localparam logic [OP_W-1:0] OP_AND = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR = 3'b100;
   localparam logic [OP_W-1:0] OP_LDA = 3'b101;
   localparam logic [OP_W-1:0] OP_STO = 3'b110;
   localparam logic [OP_W-1:0] OP_JMP = 3'b111;

   // ALU function selects
   localparam logic [ALU_W-1:0] ALU_PASS = 2'b00;
   localparam logic [ALU_W-1:0] ALU_ADD  = 2'b01;
   localparam logic [ALU_W-1:0] ALU_AND  = 2'b10;
   localparam logic [ALU_W-1:0] ALU_XOR  = 2'b11;

   // Sequencer state codes, visible on the state output
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_MEM_RD = 3'd3,
      ST_WB     = 3'd4,
      ST_MEM_WR = 3'd5,
      ST_HALT   = 3'd6
   } state_e;

   // Per-cycle memory strobes and datapath enables
   typedef struct packed {
      logic             mem_req;
      logic             mem_we;
      logic             addr_sel;
      logic             ir_load;
      logic             pc_inc;
      logic             pc_load;
      logic             acc_load;
      logic [ALU_W-1:0] alu_op;
   } ctrl_t;

   // States that hold mem_req high and therefore run the ack timer
   function automatic logic is_mem_state(input state_e s);
      return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
   endfunction

   // ALU select applied during write-back; LDA passes memory data through
   function automatic logic [ALU_W-1:0] alu_op_for(input logic [OP_W-1:0] op);
      logic [ALU_W-1:0] sel;
      case (op)
         OP_ADD:  sel = ALU_ADD;
         OP_AND:  sel = ALU_AND;
         OP_XOR:  sel = ALU_XOR;
         default: sel = ALU_PASS;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/cpu_ack_timer.sv
// Memory acknowledge watchdog: counts unacknowledged request cycles and
// flags the cycle in which the count would reach TIMEOUT without an ack.
module cpu_ack_timer
   import cpu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count,
   output logic expired
);

   logic [WAIT_W-1:0] cnt_q;
   logic [WAIT_W-1:0] cnt_d;

   // Expiry only while still waiting, so an ack on the last cycle wins
   assign expired = count && (cnt_q == WAIT_W'(TIMEOUT - 1));

   // Clear on entry to a request state, otherwise count wait cycles
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (count) begin
         cnt_d = cnt_q + WAIT_W'(1);
      end
   end

   // Wait counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: fetch/decode/execute FSM driving memory
// strobes and datapath enables, with an ack watchdog that halts on bus error.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   input  logic [OP_W-1:0]      instr_op,
   input  logic                 mem_ack,
   input  logic                 acc_zero,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 addr_sel,
   output logic                 ir_load,
   output logic                 pc_inc,
   output logic                 pc_load,
   output logic                 acc_load,
   output logic [ALU_W-1:0]     alu_op,
   output logic                 halted,
   output logic                 bus_err,
   output logic [STATE_W-1:0]   state
);

   state_e          state_q;
   state_e          state_d;
   logic [OP_W-1:0] op_q;
   logic [OP_W-1:0] op_d;
   logic            halted_q;
   logic            halted_d;
   logic            bus_err_q;
   logic            bus_err_d;
   ctrl_t           ctrl_c;
   logic            timer_clear_c;
   logic            timer_count_c;
   logic            timer_expired;

   // Timer runs off the registered state so it never loops through the FSM logic
   assign timer_count_c = is_mem_state(state_q) && !mem_ack;
   assign timer_clear_c = is_mem_state(state_d) && (state_d != state_q);

   cpu_ack_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_ack_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clear_c),
      .count   (timer_count_c),
      .expired (timer_expired)
   );

   // Next-state, opcode latch, status and per-state control strobes
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      bus_err_d = bus_err_q;
      ctrl_c    = '0;

      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_FETCH;
            end
         end

         ST_FETCH: begin
            ctrl_c.mem_req = 1'b1;
            if (mem_ack) begin
               ctrl_c.ir_load = 1'b1;
               ctrl_c.pc_inc  = 1'b1;
               op_d           = instr_op;
               state_d        = ST_DECODE;
            end else if (timer_expired) begin
               bus_err_d = 1'b1;
               state_d   = ST_HALT;
            end
         end

         ST_DECODE: begin
            case (op_q)
               OP_HLT: state_d = ST_HALT;
               OP_SKZ: begin
                  ctrl_c.pc_inc = acc_zero;
                  state_d       = ST_FETCH;
               end
               OP_JMP: begin
                  ctrl_c.pc_load = 1'b1;
                  state_d        = ST_FETCH;
               end
               OP_STO:  state_d = ST_MEM_WR;
               default: state_d = ST_MEM_RD;
            endcase
         end

         ST_MEM_RD: begin
            ctrl_c.mem_req  = 1'b1;
            ctrl_c.addr_sel = 1'b1;
            if (mem_ack) begin
               state_d = ST_WB;
            end else if (timer_expired) begin
               bus_err_d = 1'b1;
               state_d   = ST_HALT;
            end
         end

         ST_WB: begin
            ctrl_c.acc_load = 1'b1;
            ctrl_c.alu_op   = alu_op_for(op_q);
            state_d         = ST_FETCH;
         end

         ST_MEM_WR: begin
            ctrl_c.mem_req  = 1'b1;
            ctrl_c.mem_we   = 1'b1;
            ctrl_c.addr_sel = 1'b1;
            if (mem_ack) begin
               state_d = ST_FETCH;
            end else if (timer_expired) begin
               bus_err_d = 1'b1;
               state_d   = ST_HALT;
            end
         end

         ST_HALT: begin
            if (!run) begin
               bus_err_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      halted_d = (state_d == ST_HALT);
   end

   // State, opcode and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_HLT;
         halted_q  <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         halted_q  <= halted_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign mem_req  = ctrl_c.mem_req;
   assign mem_we   = ctrl_c.mem_we;
   assign addr_sel = ctrl_c.addr_sel;
   assign ir_load  = ctrl_c.ir_load;
   assign pc_inc   = ctrl_c.pc_inc;
   assign pc_load  = ctrl_c.pc_load;
   assign acc_load = ctrl_c.acc_load;
   assign alu_op   = ctrl_c.alu_op;
   assign halted   = halted_q;
   assign bus_err  = bus_err_q;
   assign state    = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer (TIMEOUT=4): walks LDA, ADD with a
// last-cycle ack, SKZ both ways, JMP, STO bus timeout, HLT and reset mid-write.
module tb_cpu_sequencer;

   logic       clk;
   logic       rst_n;
   logic       run;
   logic [2:0] instr_op;
   logic       mem_ack;
   logic       acc_zero;
   logic       mem_req;
   logic       mem_we;
   logic       addr_sel;
   logic       ir_load;
   logic       pc_inc;
   logic       pc_load;
   logic       acc_load;
   logic [1:0] alu_op;
   logic       halted;
   logic       bus_err;
   logic [2:0] state;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected state codes
   localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2,
                          S_RD = 3'd3, S_WB = 3'd4, S_WR = 3'd5, S_HALT = 3'd6;

   // Strobe vector {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, acc_load, alu_op}
   localparam logic [8:0] K_NONE  = 9'b000_0000_00;
   localparam logic [8:0] K_FWAIT = 9'b100_0000_00;
   localparam logic [8:0] K_FACK  = 9'b100_1100_00;
   localparam logic [8:0] K_RD    = 9'b101_0000_00;
   localparam logic [8:0] K_WR    = 9'b111_0000_00;
   localparam logic [8:0] K_PCINC = 9'b000_0100_00;
   localparam logic [8:0] K_PCLD  = 9'b000_0010_00;
   localparam logic [8:0] K_WBLDA = 9'b000_0001_00;
   localparam logic [8:0] K_WBADD = 9'b000_0001_01;

   cpu_sequencer #(
      .TIMEOUT (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .instr_op (instr_op),
      .mem_ack  (mem_ack),
      .acc_zero (acc_zero),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .addr_sel (addr_sel),
      .ir_load  (ir_load),
      .pc_inc   (pc_inc),
      .pc_load  (pc_load),
      .acc_load (acc_load),
      .alu_op   (alu_op),
      .halted   (halted),
      .bus_err  (bus_err),
      .state    (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every output against the expected values for the current cycle
   task automatic check_outs(input string tag, input logic [2:0] e_state,
                             input logic [8:0] e_strb, input logic e_halt,
                             input logic e_berr);
      logic [8:0] strb;
      strb = {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, acc_load, alu_op};
      chk({tag, ".state"},   16'(state),   16'(e_state));
      chk({tag, ".strobes"}, 16'(strb),    16'(e_strb));
      chk({tag, ".halted"},  16'(halted),  16'(e_halt));
      chk({tag, ".bus_err"}, 16'(bus_err), 16'(e_berr));
   endtask

   // Apply inputs for one cycle, check mid-cycle, then advance past the edge
   task automatic cyc(input string tag, input logic i_run, input logic [2:0] i_op,
                      input logic i_ack, input logic i_az, input logic [2:0] e_state,
                      input logic [8:0] e_strb, input logic e_halt, input logic e_berr);
      run      = i_run;
      instr_op = i_op;
      mem_ack  = i_ack;
      acc_zero = i_az;
      #1;
      check_outs(tag, e_state, e_strb, e_halt, e_berr);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      run      = 1'b0;
      instr_op = 3'b000;
      mem_ack  = 1'b0;
      acc_zero = 1'b0;
      #1;
      check_outs("reset", S_IDLE, K_NONE, 1'b0, 1'b0);
      run = 1'b1;
      @(posedge clk);
      #1;
      check_outs("reset_hold_run", S_IDLE, K_NONE, 1'b0, 1'b0);
      rst_n = 1'b1;

      // LDA, immediate acks: FETCH, DECODE, MEM_RD, WB
      cyc("lda_idle",   1, 3'b000, 0, 0, S_IDLE,  K_NONE,  0, 0);
      cyc("lda_fetch",  1, 3'b101, 1, 0, S_FETCH, K_FACK,  0, 0);
      cyc("lda_decode", 1, 3'b000, 1, 1, S_DEC,   K_NONE,  0, 0);
      cyc("lda_memrd",  1, 3'b000, 1, 0, S_RD,    K_RD,    0, 0);
      cyc("lda_wb",     1, 3'b000, 0, 0, S_WB,    K_WBLDA, 0, 0);

      // ADD, run dropped mid-instruction, ack on the last allowed wait cycle
      cyc("add_fetch",  0, 3'b010, 1, 0, S_FETCH, K_FACK,  0, 0);
      cyc("add_decode", 0, 3'b000, 0, 0, S_DEC,   K_NONE,  0, 0);
      cyc("add_wait1",  0, 3'b000, 0, 0, S_RD,    K_RD,    0, 0);
      cyc("add_wait2",  0, 3'b000, 0, 0, S_RD,    K_RD,    0, 0);
      cyc("add_wait3",  0, 3'b000, 0, 0, S_RD,    K_RD,    0, 0);
      cyc("add_ack",    0, 3'b000, 1, 0, S_RD,    K_RD,    0, 0);
      cyc("add_wb",     0, 3'b000, 0, 0, S_WB,    K_WBADD, 0, 0);

      // SKZ with acc_zero=1 then 0
      cyc("skz1_fetch", 0, 3'b001, 1, 0, S_FETCH, K_FACK,  0, 0);
      cyc("skz1_dec",   0, 3'b000, 0, 1, S_DEC,   K_PCINC, 0, 0);
      cyc("skz0_fetch", 0, 3'b001, 1, 1, S_FETCH, K_FACK,  0, 0);
      cyc("skz0_dec",   0, 3'b000, 0, 0, S_DEC,   K_NONE,  0, 0);

      // JMP with one fetch wait cycle
      cyc("jmp_fwait",  0, 3'b111, 0, 0, S_FETCH, K_FWAIT, 0, 0);
      cyc("jmp_fetch",  0, 3'b111, 1, 0, S_FETCH, K_FACK,  0, 0);
      cyc("jmp_dec",    0, 3'b000, 0, 1, S_DEC,   K_PCLD,  0, 0);

      // STO with no ack: bus error after four wait cycles
      cyc("sto_fetch",  0, 3'b110, 1, 0, S_FETCH, K_FACK,  0, 0);
      cyc("sto_dec",    0, 3'b000, 0, 0, S_DEC,   K_NONE,  0, 0);
      cyc("sto_wait1",  0, 3'b000, 0, 0, S_WR,    K_WR,    0, 0);
      cyc("sto_wait2",  0, 3'b000, 0, 0, S_WR,    K_WR,    0, 0);
      cyc("sto_wait3",  0, 3'b000, 0, 0, S_WR,    K_WR,    0, 0);
      cyc("sto_wait4",  1, 3'b000, 0, 0, S_WR,    K_WR,    0, 0);
      cyc("berr_halt",  1, 3'b000, 0, 0, S_HALT,  K_NONE,  1, 1);
      cyc("berr_hold",  0, 3'b000, 1, 0, S_HALT,  K_NONE,  1, 1);
      cyc("berr_idle",  0, 3'b000, 0, 0, S_IDLE,  K_NONE,  0, 0);

      // HLT: held in HALT while run=1, then IDLE, then FETCH
      cyc("hlt_idle",   1, 3'b000, 0, 0, S_IDLE,  K_NONE,  0, 0);
      cyc("hlt_fetch",  1, 3'b000, 1, 0, S_FETCH, K_FACK,  0, 0);
      cyc("hlt_dec",    1, 3'b000, 0, 0, S_DEC,   K_NONE,  0, 0);
      cyc("hlt_halt1",  1, 3'b000, 0, 0, S_HALT,  K_NONE,  1, 0);
      cyc("hlt_halt2",  0, 3'b000, 0, 0, S_HALT,  K_NONE,  1, 0);
      cyc("hlt_idle2",  1, 3'b000, 0, 0, S_IDLE,  K_NONE,  0, 0);

      // STO then reset asserted mid-write
      cyc("rst_fetch",  1, 3'b110, 1, 0, S_FETCH, K_FACK,  0, 0);
      cyc("rst_dec",    1, 3'b000, 0, 0, S_DEC,   K_NONE,  0, 0);
      run     = 1'b1;
      mem_ack = 1'b0;
      #1;
      check_outs("rst_memwr", S_WR, K_WR, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check_outs("rst_async", S_IDLE, K_NONE, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_outs("rst_held", S_IDLE, K_NONE, 1'b0, 1'b0);
      rst_n = 1'b1;
      cyc("post_rst_idle0", 0, 3'b000, 0, 0, S_IDLE,  K_NONE,  0, 0);
      cyc("post_rst_run",   1, 3'b000, 0, 0, S_IDLE,  K_NONE,  0, 0);
      cyc("post_rst_fetch", 1, 3'b000, 0, 0, S_FETCH, K_FWAIT, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
